// File: rtl/btn_intr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : btn_intr_arbiter_if
// Description : Request/ack and status bundle between button sources, the
//               RAT CPU and the interrupt arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface btn_intr_arbiter_if #(
    parameter int N_SRC = 4
);
    localparam int ID_W = $clog2(N_SRC);

    logic [N_SRC-1:0] SRC_PULSE;
    logic [N_SRC-1:0] INT_MASK;
    logic             ACK;
    logic             CLR_ERR;
    logic             INTR;
    logic [ID_W-1:0]  SRC_ID;
    logic             BUSY;
    logic [N_SRC-1:0] PEND_OUT;
    logic [N_SRC-1:0] OVERRUN;
    logic             TIMEOUT_ERR;

    // CPU/button side
    modport master (
        output SRC_PULSE, INT_MASK, ACK, CLR_ERR,
        input  INTR, SRC_ID, BUSY, PEND_OUT, OVERRUN, TIMEOUT_ERR
    );

    // arbiter side
    modport slave (
        input  SRC_PULSE, INT_MASK, ACK, CLR_ERR,
        output INTR, SRC_ID, BUSY, PEND_OUT, OVERRUN, TIMEOUT_ERR
    );
endinterface
`default_nettype wire

// File: rtl/btn_intr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : btn_intr_arbiter
// Description : Round-robin arbiter sharing one RAT interrupt line among
//               N_SRC one-shot button sources, with ACK/timeout handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_intr_arbiter #(
    parameter int N_SRC        = 4,
    parameter int INTR_CLKS    = 3,
    parameter int TIMEOUT_CLKS = 255
) (
    input  wire logic         CLK,
    input  wire logic         RST_N,
    btn_intr_arbiter_if.slave bus
);
    localparam int c_ID_W   = $clog2(N_SRC);
    localparam int c_PW_W   = $clog2(INTR_CLKS + 1);
    localparam int c_CNT_W  = (c_PW_W > 8) ? c_PW_W : 8;

    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_PULSE_LAST = c_CNT_W'(INTR_CLKS - 1);
    localparam logic [c_CNT_W-1:0] c_TO_LAST    = c_CNT_W'(TIMEOUT_CLKS - 1);
    localparam logic [c_ID_W-1:0]  c_LAST_RST   = c_ID_W'(N_SRC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [c_ID_W-1:0]  r_src_id;
    logic [c_ID_W-1:0]  r_last_id;
    logic [N_SRC-1:0]   r_prev;
    logic [N_SRC-1:0]   r_pend;
    logic [N_SRC-1:0]   r_ovr;
    logic               r_to_err;

    logic [N_SRC-1:0]   w_rise;
    logic [N_SRC-1:0]   w_elig;
    logic [N_SRC-1:0]   w_clr;
    logic [N_SRC-1:0]   w_ovr_set;
    logic [c_ID_W-1:0]  w_cand;
    logic [c_ID_W-1:0]  w_grant_id;
    logic               w_grant_vld;
    logic               w_grant;
    logic               w_to_set;
    logic               w_intr;
    logic               w_busy;

    assign w_rise = bus.SRC_PULSE & ~r_prev;
    assign w_elig = r_pend & ~bus.INT_MASK;

    // First eligible index strictly after the last winner, wrapping
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = '0;
        w_cand      = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            w_cand = c_ID_W'((int'(r_last_id) + k) % N_SRC);
            if (!w_grant_vld && w_elig[w_cand]) begin
                w_grant_vld = 1'b1;
                w_grant_id  = w_cand;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_grant     = 1'b0;
        w_to_set    = 1'b0;
        w_intr      = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_vld) begin
                    w_grant     = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_PULSE;
                end
            end
            S_PULSE: begin
                w_intr = 1'b1;
                w_busy = 1'b1;
                if (r_cnt == c_PULSE_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_WAIT;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            S_WAIT: begin
                w_busy = 1'b1;
                // ACK on the last allowed cycle still counts as a clean ACK
                if (bus.ACK) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == c_TO_LAST) begin
                    w_to_set    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // A new press on the granted source survives its own clear, without overrun
    always_comb begin
        w_clr = '0;
        if (w_grant) begin
            w_clr[w_grant_id] = 1'b1;
        end
        w_ovr_set = w_rise & r_pend & ~w_clr;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_src_id  <= '0;
            r_last_id <= c_LAST_RST;
            r_prev    <= '0;
            r_pend    <= '0;
            r_ovr     <= '0;
            r_to_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_prev  <= bus.SRC_PULSE;
            r_pend  <= (r_pend & ~w_clr) | w_rise;
            if (w_grant) begin
                r_src_id  <= w_grant_id;
                r_last_id <= w_grant_id;
            end
            r_ovr    <= (bus.CLR_ERR ? '0 : r_ovr) | w_ovr_set;
            r_to_err <= (bus.CLR_ERR ? 1'b0 : r_to_err) | w_to_set;
        end
    end

    assign bus.INTR        = w_intr;
    assign bus.BUSY        = w_busy;
    assign bus.SRC_ID      = r_src_id;
    assign bus.PEND_OUT    = r_pend;
    assign bus.OVERRUN     = r_ovr;
    assign bus.TIMEOUT_ERR = r_to_err;

endmodule
`default_nettype wire

// File: tb/tb_btn_intr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_intr_arbiter
// Description : Directed self-checking bench for btn_intr_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_intr_arbiter;
    localparam int c_N       = 4;
    localparam int c_PW      = 3;
    localparam int c_TIMEOUT = 255;

    logic CLK;
    logic RST_N;
    int   n_checks;
    int   n_errors;

    btn_intr_arbiter_if #(.N_SRC(c_N)) bus ();

    btn_intr_arbiter #(
        .N_SRC        (c_N),
        .INTR_CLKS    (c_PW),
        .TIMEOUT_CLKS (c_TIMEOUT)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] pulse;
        logic [3:0] mask;
        logic       ack;
        logic       clr;
        logic       exp_intr;
        logic       exp_busy;
        logic [1:0] exp_id;
        logic [3:0] exp_pend;
        logic [3:0] exp_ovr;
        logic       exp_to;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        bus.SRC_PULSE = '0;
        bus.INT_MASK  = '0;
        bus.ACK       = 1'b0;
        bus.CLR_ERR   = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    task automatic wait_intr();
        int n;
        n = 0;
        while (!bus.INTR && n < 20) begin
            n++;
            cyc();
        end
        if (!bus.INTR) check("wait_intr_timeout", 32'd0, 32'd1);
    endtask

    // From anywhere before a grant: wait for INTR, check ID and pulse width,
    // return at the first WAIT_ACK sample.
    task automatic enter(input logic [1:0] exp_id);
        int w;
        wait_intr();
        check("src_id", 32'(bus.SRC_ID), 32'(exp_id));
        w = 0;
        while (bus.INTR && w < 10) begin
            w++;
            cyc();
        end
        check("intr_width", 32'(w), 32'(c_PW));
        check("busy_in_wait", 32'(bus.BUSY), 32'd1);
    endtask

    task automatic serve(input logic [1:0] exp_id);
        enter(exp_id);
        bus.ACK = 1'b1;
        cyc();
        bus.ACK = 1'b0;
        check("busy_after_ack", 32'(bus.BUSY), 32'd0);
    endtask

    initial begin
        int n;
        n_checks = 0;
        n_errors = 0;

        // Reset state, then single press on source 2 held for 3 clocks
        //              pulse    mask     ack   clr   intr  busy  id     pend     ovr      to
        vecs[0] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0};
        vecs[1] = '{4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0100, 4'b0000, 1'b0};
        vecs[2] = '{4'b0100, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 4'b0000, 4'b0000, 1'b0};
        vecs[3] = '{4'b0100, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 4'b0000, 4'b0000, 1'b0};
        vecs[4] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 4'b0000, 4'b0000, 1'b0};
        vecs[5] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0000, 4'b0000, 1'b0};
        vecs[6] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0000, 4'b0000, 1'b0};
        vecs[7] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0000, 4'b0000, 1'b0};

        do_reset();
        check("rst_intr", 32'(bus.INTR), 32'd0);
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_pend", 32'(bus.PEND_OUT), 32'd0);
        check("rst_ovr",  32'(bus.OVERRUN), 32'd0);
        check("rst_to",   32'(bus.TIMEOUT_ERR), 32'd0);

        for (int i = 0; i < 8; i++) begin
            bus.SRC_PULSE = vecs[i].pulse;
            bus.INT_MASK  = vecs[i].mask;
            bus.ACK       = vecs[i].ack;
            bus.CLR_ERR   = vecs[i].clr;
            cyc();
            check($sformatf("v%0d_intr", i), 32'(bus.INTR),        32'(vecs[i].exp_intr));
            check($sformatf("v%0d_busy", i), 32'(bus.BUSY),        32'(vecs[i].exp_busy));
            check($sformatf("v%0d_id",   i), 32'(bus.SRC_ID),      32'(vecs[i].exp_id));
            check($sformatf("v%0d_pend", i), 32'(bus.PEND_OUT),    32'(vecs[i].exp_pend));
            check($sformatf("v%0d_ovr",  i), 32'(bus.OVERRUN),     32'(vecs[i].exp_ovr));
            check($sformatf("v%0d_to",   i), 32'(bus.TIMEOUT_ERR), 32'(vecs[i].exp_to));
        end

        // Round-robin: all four pending, then a re-press on 0 after servicing 1
        do_reset();
        bus.SRC_PULSE = 4'b1111;
        cyc();
        bus.SRC_PULSE = 4'b0000;
        check("rr_pend", 32'(bus.PEND_OUT), 32'hF);
        serve(2'd0);
        serve(2'd1);
        bus.SRC_PULSE = 4'b0001;
        cyc();
        bus.SRC_PULSE = 4'b0000;
        serve(2'd2);
        serve(2'd3);
        serve(2'd0);
        check("rr_pend_end", 32'(bus.PEND_OUT), 32'h0);

        // Mask: source 0 latched but not granted until unmasked
        do_reset();
        bus.INT_MASK  = 4'b0001;
        bus.SRC_PULSE = 4'b1001;
        cyc();
        bus.SRC_PULSE = 4'b0000;
        serve(2'd3);
        repeat (3) cyc();
        check("mask_idle_busy", 32'(bus.BUSY), 32'd0);
        check("mask_pend", 32'(bus.PEND_OUT), 32'b0001);
        bus.INT_MASK = 4'b0000;
        serve(2'd0);
        check("mask_pend_end", 32'(bus.PEND_OUT), 32'h0);

        // Overrun, clear, then a rise coinciding with the grant
        do_reset();
        bus.INT_MASK  = 4'b0010;
        bus.SRC_PULSE = 4'b0010; cyc();
        bus.SRC_PULSE = 4'b0000; cyc();
        check("ovr_none_yet", 32'(bus.OVERRUN), 32'h0);
        bus.SRC_PULSE = 4'b0010; cyc();
        bus.SRC_PULSE = 4'b0000; cyc();
        check("ovr_set", 32'(bus.OVERRUN), 32'b0010);
        check("ovr_pend", 32'(bus.PEND_OUT), 32'b0010);
        bus.CLR_ERR = 1'b1; cyc();
        bus.CLR_ERR = 1'b0;
        check("ovr_clr", 32'(bus.OVERRUN), 32'h0);
        bus.INT_MASK  = 4'b0000;
        bus.SRC_PULSE = 4'b0010;
        cyc();
        bus.SRC_PULSE = 4'b0000;
        check("coin_intr", 32'(bus.INTR), 32'd1);
        check("coin_pend", 32'(bus.PEND_OUT), 32'b0010);
        check("coin_ovr", 32'(bus.OVERRUN), 32'h0);
        serve(2'd1);
        serve(2'd1);
        check("coin_pend_end", 32'(bus.PEND_OUT), 32'h0);

        // Timeout with no ACK
        do_reset();
        bus.SRC_PULSE = 4'b0001; cyc();
        bus.SRC_PULSE = 4'b0000;
        enter(2'd0);
        n = 0;
        while (bus.BUSY && n < 400) begin
            n++;
            cyc();
        end
        check("to_cycles", 32'(n), 32'(c_TIMEOUT));
        check("to_err", 32'(bus.TIMEOUT_ERR), 32'd1);
        bus.CLR_ERR = 1'b1; cyc();
        bus.CLR_ERR = 1'b0;
        check("to_clr", 32'(bus.TIMEOUT_ERR), 32'd0);

        // ACK on the final WAIT_ACK cycle
        bus.SRC_PULSE = 4'b0001; cyc();
        bus.SRC_PULSE = 4'b0000;
        enter(2'd0);
        repeat (c_TIMEOUT - 1) cyc();
        check("to_last_busy", 32'(bus.BUSY), 32'd1);
        bus.ACK = 1'b1; cyc();
        bus.ACK = 1'b0;
        check("to_ack_busy", 32'(bus.BUSY), 32'd0);
        check("to_ack_err", 32'(bus.TIMEOUT_ERR), 32'd0);

        // Asynchronous reset in the middle of PULSE
        do_reset();
        bus.SRC_PULSE = 4'b0110; cyc();
        bus.SRC_PULSE = 4'b0000; cyc();
        check("ar_intr_pre", 32'(bus.INTR), 32'd1);
        check("ar_id_pre", 32'(bus.SRC_ID), 32'd1);
        check("ar_pend_pre", 32'(bus.PEND_OUT), 32'b0100);
        #2;
        RST_N = 1'b0;
        #1;
        check("ar_intr", 32'(bus.INTR), 32'd0);
        check("ar_busy", 32'(bus.BUSY), 32'd0);
        check("ar_pend", 32'(bus.PEND_OUT), 32'h0);
        @(posedge CLK);
        @(posedge CLK);
        #3;
        RST_N = 1'b1;
        bus.SRC_PULSE = 4'b0101; cyc();
        bus.SRC_PULSE = 4'b0000;
        check("ar_pend_post", 32'(bus.PEND_OUT), 32'b0101);
        serve(2'd0);
        serve(2'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/btn_intr_arbiter.md
Name: btn_intr_arbiter

Overview:
- Shares the single RAT CPU interrupt line among N_SRC debounced one-shot button sources.
- Each source is a debounced one-shot output that stays high for several clocks per press.
- The block latches each press as a pending request and picks one pending source round-robin.
- It drives a fixed-width INTR pulse with the winning source ID, then holds until the CPU ISR acknowledges or a timeout expires.

Parameters:
- N_SRC, 4, number of button sources (2..8).
- INTR_CLKS, 3, width of the INTR pulse in CLK cycles (>=1).
- TIMEOUT_CLKS, 255, max cycles in WAIT_ACK before an abandoned service (>=1, fits 8 bits).

Ports:
- CLK  in  1  50 MHz RAT clock; all state updates on rising edge.
- RST_N  in  1  reset, asynchronous and active-low.
- SRC_PULSE  in  N_SRC  one-shot inputs; bit i is source i.
- INT_MASK  in  N_SRC  1 = source masked from grant; it still latches pending.
- ACK  in  1  single-cycle strobe from CPU output-port decode.
- CLR_ERR  in  1  single-cycle strobe; clears the sticky error flags.
- INTR  out  1  interrupt to RAT CPU.
- SRC_ID  out  clog2(N_SRC)  ID of the source being serviced.
- BUSY  out  1  high in PULSE and WAIT_ACK.
- PEND_OUT  out  N_SRC  current pending register.
- OVERRUN  out  N_SRC  sticky: press arrived while that source was already pending.
- TIMEOUT_ERR  out  1  sticky: a service ended by timeout instead of ACK.

Behaviour:
- Reset (async, RST_N=0):
  - State = IDLE.
  - INTR, BUSY, SRC_ID, PEND, OVERRUN, TIMEOUT_ERR, edge-detect register and counter all = 0.
  - LAST_ID = N_SRC-1, so source 0 has first priority after reset.
  - Reset mid-service drops the service and all pending requests immediately.
- Edge detect:
  - prev register holds last cycle's SRC_PULSE.
  - rise[i] = SRC_PULSE[i] & ~prev[i].
  - A level held for multiple clocks counts as one event.
- Pending register:
  - rise[i] sets PEND[i].
  - If rise[i] arrives while PEND[i] is already 1 (before this cycle's update), set OVERRUN[i].
  - A grant clears PEND[id] in the grant cycle.
  - If rise[id] coincides with that clear, set wins: PEND[id] stays 1 and no overrun is flagged.
- Eligible = PEND & ~INT_MASK.
- FSM states:
  - IDLE: INTR=0, BUSY=0. If Eligible != 0, grant the first eligible index searching LAST_ID+1, LAST_ID+2, ... modulo N_SRC. On grant: SRC_ID and LAST_ID <= index, clear PEND[index], counter <= 0, next state PULSE. Otherwise stay in IDLE.
  - PULSE: INTR=1, BUSY=1. Counter increments each cycle. Exactly INTR_CLKS consecutive INTR-high cycles, then go to WAIT_ACK with counter <= 0. ACK is ignored in this state.
  - WAIT_ACK: INTR=0, BUSY=1.
    - ACK=1: go to IDLE.
    - Else if counter == TIMEOUT_CLKS-1: set TIMEOUT_ERR and go to IDLE.
    - Else increment the counter.
    - ACK on the final timeout cycle counts as ACK; TIMEOUT_ERR is not set.
  - Illegal state encoding: go to IDLE with INTR=0.
- Timing:
  - Minimum gap between INTR pulses is 1 IDLE cycle: ACK, then IDLE grant cycle, then PULSE.
  - Latency from a rise on an eligible source with the FSM idle to INTR high is 2 cycles: latch into PEND, grant, PULSE.
- SRC_ID holds its value after the service ends until the next grant, so the ISR may read it late.
- CLR_ERR clears OVERRUN and TIMEOUT_ERR. If a set event occurs in the same cycle, set wins.
- Changing INT_MASK affects only future grants; an in-flight service is never aborted.

Test Plan:
- Single press: after reset, SRC_PULSE[2] high for 3 clks → PEND=0100, then grant; INTR high exactly 3 clks with SRC_ID=2; ACK in WAIT_ACK → IDLE, PEND=0000, no error flags set.
- Round-robin: PEND=1111 preset by simultaneous pulses; ACK each service promptly → service order 0,1,2,3. New pulse on source 0 after servicing 1 → order continues 2,3,0.
- Mask: INT_MASK=0001 with pulses on 0 and 3 → only 3 serviced, PEND=0001 remains. Then INT_MASK=0000 → source 0 is serviced next.
- Overrun and coincidence: source 1 pulses twice while pending → OVERRUN=0010. Rise on source 1 in its grant cycle → PEND[1] stays 1, OVERRUN bit not newly set. CLR_ERR → OVERRUN=0000.
- Timeout: grant with no ACK, TIMEOUT_CLKS=255 → 255 WAIT_ACK cycles, then TIMEOUT_ERR=1 and IDLE. Repeat with ACK on cycle 255 → TIMEOUT_ERR stays 0.
- Async reset: assert RST_N=0 mid-PULSE, between clock edges → INTR, BUSY, PEND drop immediately. After release, the first grant goes to source 0.
